// File: rtl/nt_level_integrator.sv
// Per-neurotransmitter level integrator. Tick-prescaled inc/dec commands move a
// saturating level register; prolonged idleness drifts it back toward BASELINE.
module nt_level_integrator #(
  parameter int WIDTH        = 8,
  parameter int BASELINE     = 128,
  parameter int SLOW_PERIOD  = 8,
  parameter int FAST_PERIOD  = 2,
  parameter int DRIFT_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       level_q,
  output logic             at_max,
  output logic             at_min,
  output logic             update
);

  localparam int CW = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
  localparam int IW = (DRIFT_PERIOD > 1) ? $clog2(DRIFT_PERIOD) : 1;
  localparam logic [CW-1:0]    SLOW_M1  = CW'(SLOW_PERIOD - 1);
  localparam logic [CW-1:0]    FAST_M1  = CW'(FAST_PERIOD - 1);
  localparam logic [IW-1:0]    DRIFT_M1 = IW'(DRIFT_PERIOD - 1);
  localparam logic [WIDTH-1:0] BASE     = WIDTH'(BASELINE);
  localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, {WIDTH{1'b1}}};

  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idle;
  logic [WIDTH-1:0] r_level;
  logic             r_update;

  logic [CW-1:0]    w_period_m1;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_evt;
  logic [IW-1:0]    w_idle_nxt;
  logic [WIDTH-1:0] w_level_nxt;
  logic [WIDTH:0]   w_up_ext;
  logic [WIDTH:0]   w_dn_ext;

  assign w_period_m1 = fast ? FAST_M1 : SLOW_M1;
  assign w_up_ext    = {1'b0, r_level} + (WIDTH+1)'(1);
  assign w_dn_ext    = {1'b0, r_level} - (WIDTH+1)'(1);

  // >= rather than == so a shrinking period never lets the counter run past it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_evt     = 1'b0;
    if (ena) begin
      if (r_cnt >= w_period_m1) begin
        w_cnt_nxt = '0;
        w_evt     = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    w_idle_nxt  = r_idle;
    if (w_evt) begin
      case ({inc, dec})
        2'b10: begin
          w_idle_nxt = '0;
          if (w_up_ext > MAX_EXT) begin
            w_level_nxt = r_level;
          end else begin
            w_level_nxt = w_up_ext[WIDTH-1:0];
          end
        end
        2'b01: begin
          w_idle_nxt = '0;
          // Borrow out of the extended subtract means the level was already 0.
          if (w_dn_ext[WIDTH]) begin
            w_level_nxt = r_level;
          end else begin
            w_level_nxt = w_dn_ext[WIDTH-1:0];
          end
        end
        default: begin
          if (r_idle == DRIFT_M1) begin
            w_idle_nxt = '0;
            if (r_level < BASE) begin
              w_level_nxt = w_up_ext[WIDTH-1:0];
            end else if (r_level > BASE) begin
              w_level_nxt = w_dn_ext[WIDTH-1:0];
            end else begin
              w_level_nxt = r_level;
            end
          end else begin
            w_idle_nxt = r_idle + IW'(1);
          end
        end
      endcase
    end else begin
      w_level_nxt = r_level;
      w_idle_nxt  = r_idle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idle   <= '0;
      r_level  <= BASE;
      r_update <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idle   <= w_idle_nxt;
      r_level  <= w_level_nxt;
      r_update <= w_evt;
    end
  end

  assign level   = r_level;
  assign level_q = r_level[WIDTH-1:WIDTH-2];
  assign at_max  = (r_level == {WIDTH{1'b1}});
  assign at_min  = (r_level == {WIDTH{1'b0}});
  assign update  = r_update;

endmodule

// File: tb/tb_nt_level_integrator.sv
// Scoreboard bench for nt_level_integrator: a behavioural model queues the
// expected level/update per clock, popped and compared after each edge.
module tb_nt_level_integrator;

  localparam int WIDTH = 8;
  localparam int BASE  = 128;
  localparam int SP    = 8;
  localparam int FP    = 2;
  localparam int DP    = 16;
  localparam int LMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic             inc = 1'b0;
  logic             dec = 1'b0;
  logic             fast = 1'b0;
  logic [WIDTH-1:0] level;
  logic [1:0]       level_q;
  logic             at_max;
  logic             at_min;
  logic             update;

  typedef struct {
    int lvl;
    int upd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_level, m_cnt, m_idle;

  nt_level_integrator #(
    .WIDTH(WIDTH), .BASELINE(BASE), .SLOW_PERIOD(SP),
    .FAST_PERIOD(FP), .DRIFT_PERIOD(DP)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec), .fast(fast),
    .level(level), .level_q(level_q), .at_max(at_max), .at_min(at_min),
    .update(update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = BASE;
    m_cnt   = 0;
    m_idle  = 0;
    sb.delete();
  endtask

  // One clock: advance the model, queue its prediction, clock the DUT, compare.
  task automatic step();
    exp_t e;
    exp_t g;
    int   p;
    e.upd = 0;
    if (ena) begin
      p = fast ? FP : SP;
      if (m_cnt >= p - 1) begin
        m_cnt = 0;
        e.upd = 1;
        if (inc && !dec) begin
          m_level = (m_level == LMAX) ? LMAX : m_level + 1;
          m_idle  = 0;
        end else if (dec && !inc) begin
          m_level = (m_level == 0) ? 0 : m_level - 1;
          m_idle  = 0;
        end else if (m_idle == DP - 1) begin
          m_idle = 0;
          if (m_level < BASE) m_level++;
          else if (m_level > BASE) m_level--;
        end else begin
          m_idle++;
        end
      end else begin
        m_cnt++;
      end
    end
    e.lvl = m_level;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("level", int'(level), g.lvl);
      chk("update", int'(update), g.upd);
      chk("at_max", int'(at_max), (g.lvl == LMAX) ? 1 : 0);
      chk("at_min", int'(at_min), (g.lvl == 0) ? 1 : 0);
      chk("level_q", int'(level_q), g.lvl / 64);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0; inc = 1'b0; dec = 1'b0; fast = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset values, then async reset mid-count
    do_reset();
    chk("rst_level", int'(level), 128);
    chk("rst_level_q", int'(level_q), 2);
    chk("rst_at_max", int'(at_max), 0);
    chk("rst_at_min", int'(at_min), 0);
    chk("rst_update", int'(update), 0);
    ena = 1'b1; inc = 1'b1; fast = 1'b1;
    run(5);
    chk("pre_async_level", int'(level), 130);
    #3;
    rst = 1'b1;
    #1;
    chk("async_level", int'(level), 128);
    chk("async_update", int'(update), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;

    // 2: slow increments from reset
    do_reset();
    ena = 1'b1; inc = 1'b1; fast = 1'b0;
    run(7);
    chk("t2_no_upd_e7", int'(update), 0);
    run(1);
    chk("t2_l8", int'(level), 129);
    chk("t2_u8", int'(update), 1);
    run(56);
    chk("t2_l64", int'(level), 136);

    // 3: fast increments to saturation, then saturated events
    do_reset();
    ena = 1'b1; inc = 1'b1; fast = 1'b1;
    run(254);
    chk("t3_l254", int'(level), 255);
    chk("t3_max", int'(at_max), 1);
    chk("t3_q", int'(level_q), 3);
    run(10);
    chk("t3_hold", int'(level), 255);
    chk("t3_upd", int'(update), 1);

    // 4: fast decrements to zero, then conflicting command
    do_reset();
    ena = 1'b1; dec = 1'b1; fast = 1'b1;
    run(250);
    chk("t4_l3", int'(level), 3);
    run(6);
    chk("t4_l0", int'(level), 0);
    chk("t4_min", int'(at_min), 1);
    chk("t4_q", int'(level_q), 0);
    inc = 1'b1;
    run(8);
    chk("t4_both", int'(level), 0);

    // 5: idle drift down from 140 and up from 127
    do_reset();
    ena = 1'b1; inc = 1'b1; fast = 1'b1;
    run(24);
    chk("t5_l140", int'(level), 140);
    inc = 1'b0; fast = 1'b0;
    run(127);
    chk("t5_no_drift_yet", int'(level), 140);
    run(1);
    chk("t5_l139", int'(level), 139);
    run(128);
    chk("t5_l138", int'(level), 138);
    do_reset();
    ena = 1'b1; dec = 1'b1; fast = 1'b1;
    run(2);
    chk("t5_l127", int'(level), 127);
    dec = 1'b0; fast = 1'b0;
    run(128);
    chk("t5_l128", int'(level), 128);
    run(128);
    chk("t5_stay", int'(level), 128);

    // 6a: shrinking the period with cnt=5 fires on the next edge
    do_reset();
    ena = 1'b1;
    run(5);
    fast = 1'b1;
    run(1);
    chk("t6a_upd", int'(update), 1);

    // 6b: ena low freezes everything, then the count resumes from 5
    do_reset();
    ena = 1'b1; inc = 1'b1;
    run(5);
    ena = 1'b0;
    run(20);
    chk("t6b_hold_upd", int'(update), 0);
    chk("t6b_hold_lvl", int'(level), 128);
    ena = 1'b1;
    run(2);
    chk("t6b_not_yet", int'(update), 0);
    run(1);
    chk("t6b_upd", int'(update), 1);
    chk("t6b_lvl", int'(level), 129);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
